lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Sequencing controller for the push-button digital lock. Collects B0/B1 presses into a fixed-length code, compares it against a stored combination, and counts failed attempts. Enforces a timed lockout and lets the owner reprogram the combination while unlocked. Sits between the debounced button inputs and the lock actuator / status LEDs.

## Interface
- CODE_LEN, 4: presses per code entry (≥2)
- CODE_INIT, 4'b1001: combination after reset, CODE_LEN bits; bit=1 means B1, bit=0 means B0
- MAX_FAIL, 3: consecutive mismatches that trigger lockout (≥1)
- LOCKOUT_CYC, 32: lockout duration in mClk cycles
- TIMEOUT_CYC, 16: idle cycles allowed between presses before an entry is abandoned
- mClk  in  1  system clock; all state changes on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- B0  in  1  button 0 level, debounced and synchronous to mClk
- B1  in  1  button 1 level, debounced and synchronous to mClk
- Prog  in  1  request to enter program mode; level, sampled only in OPEN
- Relock  in  1  request to relock; level, sampled only in OPEN
- correct  out  1  one-cycle pulse on a matching entry
- incorrect  out  1  one-cycle pulse on a mismatching entry
- unlocked  out  1  high in OPEN and PROG
- locked_out  out  1  high in LOCKOUT
- prog_done  out  1  one-cycle pulse when a new combination is stored
- fail_cnt  out  $clog2(MAX_FAIL+1)  current consecutive-failure count

## Operation
- Press detection: registered copy of B0/B1. A press is Bx=1 with the previous sample 0. Both rising in the same cycle is ignored: no digit, no idle-counter reset.
- Digit shift: entry register shifts left with the new digit in the LSB. The first press ends up in bit CODE_LEN-1.
- States:
  - LOCKED: first press → ENTRY, digit count=1.
  - ENTRY: each press adds a digit. The press that completes CODE_LEN digits triggers the compare:
    - Match → OPEN, correct pulse, fail_cnt←0.
    - Mismatch → fail_cnt+1, incorrect pulse. If the new count equals MAX_FAIL → LOCKOUT, otherwise → LOCKED.
  - ENTRY timeout: TIMEOUT_CYC consecutive cycles with no press → LOCKED. Partial entry is discarded, no pulse, fail_cnt unchanged.
  - OPEN: presses are ignored.
    - Relock=1 → LOCKED.
    - Prog=1 (with Relock=0) → PROG.
    - Relock and Prog together: Relock wins.
  - PROG: CODE_LEN presses form the new code. On completion the code is stored, prog_done pulses, → OPEN. Timeout → OPEN, code unchanged.
  - LOCKOUT: all presses are ignored. A down-counter loaded with LOCKOUT_CYC expires → LOCKED, fail_cnt←0.
- Reset: state LOCKED, code←CODE_INIT, fail_cnt=0, all counters 0, all outputs 0.
- Counter width is $clog2(max(LOCKOUT_CYC,TIMEOUT_CYC)+1). Counters saturate and never wrap.

## Timing
- Outputs are registered. correct, incorrect and prog_done are high for exactly the one cycle after the edge that samples the completing press.
- unlocked and locked_out change in the same cycle as the state register.
- Idle counter restarts at 0 on every press. Timeout fires on the edge where the count reaches TIMEOUT_CYC.
- LOCKOUT is high for exactly LOCKOUT_CYC cycles.
- Reset_n asserted mid-entry, mid-program or mid-lockout clears everything immediately (asynchronous). The first press can be recognised on the second mClk edge after Reset_n deasserts.
- A press that is already high at reset release is not a press: the previous-sample register resets to 1.

## Configuration
- LOCK_AUTO_RELOCK_EN defined: OPEN returns to LOCKED after TIMEOUT_CYC consecutive cycles with Prog=0, Relock=0 and no press.
- LOCK_AUTO_RELOCK_EN not defined: OPEN is left only via Relock or Prog.
- PROG behaviour is identical in both builds.

## Test plan
- Default code: press B1,B0,B0,B1 → correct pulses 1 cycle after the 4th press, unlocked=1, fail_cnt=0.
- Press B0,B0,B0,B0 three times → incorrect pulses three times, fail_cnt 1→2→3. locked_out=1 for 32 cycles, during which a press on B1 has no effect. Then LOCKED with fail_cnt=0.
- Enter B1,B0 then idle 16 cycles → back to LOCKED, no pulse. B1,B0,B0,B1 afterwards still unlocks.
- Unlocked: Prog=1, press B0,B1,B1,B0 → prog_done pulse. Relock=1 → LOCKED. Old code 1001 now gives incorrect; 0110 gives correct.
- Prog and Relock asserted together in OPEN → LOCKED. B0 and B1 rising in the same cycle during ENTRY → digit count unchanged.
- Reset_n pulsed low after 2 of 4 presses in PROG → LOCKED, code back to 1001, all outputs 0. With LOCK_AUTO_RELOCK_EN defined: after unlocking, 16 idle cycles → unlocked=0.

Source files
------------

// File: rtl/lock_sequencer.sv
// Push-button lock sequencer: collects B0/B1 presses, matches them against a stored code,
// counts failures, enforces lockout and supports reprogramming. Optional macro: LOCK_AUTO_RELOCK_EN.
module lock_sequencer #(
   parameter int unsigned                CODE_LEN    = 4,
   parameter logic [CODE_LEN-1:0]        CODE_INIT   = 4'b1001,
   parameter int unsigned                MAX_FAIL    = 3,
   parameter int unsigned                LOCKOUT_CYC = 32,
   parameter int unsigned                TIMEOUT_CYC = 16,
   localparam int unsigned               FCW         = $clog2(MAX_FAIL + 1)
) (
   input  logic           mClk,
   input  logic           Reset_n,
   input  logic           B0,
   input  logic           B1,
   input  logic           Prog,
   input  logic           Relock,
   output logic           correct,
   output logic           incorrect,
   output logic           unlocked,
   output logic           locked_out,
   output logic           prog_done,
   output logic [FCW-1:0] fail_cnt,
   output logic [2:0]     dbg_state_o
);

   localparam int unsigned CNT_MAX = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned DCW     = $clog2(CODE_LEN + 1);

   localparam logic [CW-1:0]  TIMEOUT_V  = CW'(TIMEOUT_CYC);
   localparam logic [CW-1:0]  LOCKOUT_V  = CW'(LOCKOUT_CYC);
   localparam logic [CW-1:0]  CNT_MAX_V  = CW'(CNT_MAX);
   localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
   localparam logic [DCW-1:0] CODE_LEN_V = DCW'(CODE_LEN);
   localparam logic [DCW-1:0] DIG_ONE    = DCW'(1);
   localparam logic [FCW-1:0] MAX_FAIL_V = FCW'(MAX_FAIL);
   localparam logic [FCW-1:0] FAIL_ONE   = FCW'(1);

   typedef enum logic [2:0] {
      S_LOCKED  = 3'd0,
      S_ENTRY   = 3'd1,
      S_OPEN    = 3'd2,
      S_PROG    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_e;

   state_e              state_q;
   logic                b0_prev_q;
   logic                b1_prev_q;
   logic [CODE_LEN-1:0] code_q;
   logic [CODE_LEN-1:0] entry_q;
   logic [DCW-1:0]      dig_q;
   logic [CW-1:0]       idle_q;
   logic [CW-1:0]       lock_cnt_q;
   logic [FCW-1:0]      fail_q;
   logic                correct_q;
   logic                incorrect_q;
   logic                unlocked_q;
   logic                locked_q;
   logic                prog_done_q;

   logic                rise0_d;
   logic                rise1_d;
   logic                press_d;
   logic                digit_d;
   logic [CODE_LEN-1:0] shift_d;
   logic [DCW-1:0]      ndig_d;
   logic                last_d;
   logic [CW-1:0]       idle_inc_d;
   logic                idle_exp_d;
   logic [FCW-1:0]      fail_inc_d;
   logic                lock_exp_d;

   // Simultaneous rising edges on both buttons cancel out: no digit, no idle restart.
   assign rise0_d    = B0 & ~b0_prev_q;
   assign rise1_d    = B1 & ~b1_prev_q;
   assign press_d    = rise0_d ^ rise1_d;
   assign digit_d    = rise1_d;
   assign shift_d    = {entry_q[CODE_LEN-2:0], digit_d};
   assign ndig_d     = dig_q + DIG_ONE;
   assign last_d     = (ndig_d == CODE_LEN_V);
   assign idle_inc_d = (idle_q == CNT_MAX_V) ? idle_q : idle_q + CNT_ONE;
   assign idle_exp_d = (idle_inc_d == TIMEOUT_V);
   assign fail_inc_d = (fail_q == MAX_FAIL_V) ? fail_q : fail_q + FAIL_ONE;
   assign lock_exp_d = (lock_cnt_q <= CNT_ONE);

   always_ff @(posedge mClk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_LOCKED;
         b0_prev_q   <= 1'b1;
         b1_prev_q   <= 1'b1;
         code_q      <= CODE_INIT;
         entry_q     <= '0;
         dig_q       <= '0;
         idle_q      <= '0;
         lock_cnt_q  <= '0;
         fail_q      <= '0;
         correct_q   <= 1'b0;
         incorrect_q <= 1'b0;
         unlocked_q  <= 1'b0;
         locked_q    <= 1'b0;
         prog_done_q <= 1'b0;
      end else begin
         b0_prev_q   <= B0;
         b1_prev_q   <= B1;
         correct_q   <= 1'b0;
         incorrect_q <= 1'b0;
         prog_done_q <= 1'b0;
         case (state_q)
            S_LOCKED: begin
               if (press_d) begin
                  state_q <= S_ENTRY;
                  entry_q <= {{(CODE_LEN-1){1'b0}}, digit_d};
                  dig_q   <= DIG_ONE;
                  idle_q  <= '0;
               end
            end
            S_ENTRY: begin
               if (press_d) begin
                  idle_q <= '0;
                  if (last_d) begin
                     entry_q <= '0;
                     dig_q   <= '0;
                     if (shift_d == code_q) begin
                        state_q    <= S_OPEN;
                        unlocked_q <= 1'b1;
                        correct_q  <= 1'b1;
                        fail_q     <= '0;
                     end else begin
                        incorrect_q <= 1'b1;
                        fail_q      <= fail_inc_d;
                        if (fail_inc_d == MAX_FAIL_V) begin
                           state_q    <= S_LOCKOUT;
                           locked_q   <= 1'b1;
                           lock_cnt_q <= LOCKOUT_V;
                        end else begin
                           state_q <= S_LOCKED;
                        end
                     end
                  end else begin
                     entry_q <= shift_d;
                     dig_q   <= ndig_d;
                  end
               end else if (idle_exp_d) begin
                  // Abandoned entry: drop partial digits, failure count untouched.
                  state_q <= S_LOCKED;
                  entry_q <= '0;
                  dig_q   <= '0;
                  idle_q  <= '0;
               end else begin
                  idle_q <= idle_inc_d;
               end
            end
            S_OPEN: begin
               if (Relock) begin
                  state_q    <= S_LOCKED;
                  unlocked_q <= 1'b0;
                  idle_q     <= '0;
               end else if (Prog) begin
                  state_q <= S_PROG;
                  entry_q <= '0;
                  dig_q   <= '0;
                  idle_q  <= '0;
               end
`ifdef LOCK_AUTO_RELOCK_EN
               else if (press_d) begin
                  idle_q <= '0;
               end else if (idle_exp_d) begin
                  state_q    <= S_LOCKED;
                  unlocked_q <= 1'b0;
                  idle_q     <= '0;
               end else begin
                  idle_q <= idle_inc_d;
               end
`endif
            end
            S_PROG: begin
               if (press_d) begin
                  idle_q <= '0;
                  if (last_d) begin
                     state_q     <= S_OPEN;
                     code_q      <= shift_d;
                     prog_done_q <= 1'b1;
                     entry_q     <= '0;
                     dig_q       <= '0;
                  end else begin
                     entry_q <= shift_d;
                     dig_q   <= ndig_d;
                  end
               end else if (idle_exp_d) begin
                  state_q <= S_OPEN;
                  entry_q <= '0;
                  dig_q   <= '0;
                  idle_q  <= '0;
               end else begin
                  idle_q <= idle_inc_d;
               end
            end
            S_LOCKOUT: begin
               // Expiring on count 1 keeps locked_out high for exactly LOCKOUT_CYC cycles.
               if (lock_exp_d) begin
                  state_q    <= S_LOCKED;
                  locked_q   <= 1'b0;
                  lock_cnt_q <= '0;
                  fail_q     <= '0;
               end else begin
                  lock_cnt_q <= lock_cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q    <= S_LOCKED;
               unlocked_q <= 1'b0;
               locked_q   <= 1'b0;
               entry_q    <= '0;
               dig_q      <= '0;
               idle_q     <= '0;
               lock_cnt_q <= '0;
            end
         endcase
      end
   end

   assign correct     = correct_q;
   assign incorrect   = incorrect_q;
   assign unlocked    = unlocked_q;
   assign locked_out  = locked_q;
   assign prog_done   = prog_done_q;
   assign fail_cnt    = fail_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_lock_sequencer;

   localparam logic [2:0] ST_LOCKED  = 3'd0;
   localparam logic [2:0] ST_ENTRY   = 3'd1;
   localparam logic [2:0] ST_OPEN    = 3'd2;
   localparam logic [2:0] ST_PROG    = 3'd3;
   localparam logic [2:0] ST_LOCKOUT = 3'd4;

   logic       mClk;
   logic       Reset_n;
   logic       B0;
   logic       B1;
   logic       Prog;
   logic       Relock;
   logic       correct;
   logic       incorrect;
   logic       unlocked;
   logic       locked_out;
   logic       prog_done;
   logic [1:0] fail_cnt;
   logic [2:0] dbg_state;

   int n_vec;
   int n_err;

   lock_sequencer dut (
      .mClk        (mClk),
      .Reset_n     (Reset_n),
      .B0          (B0),
      .B1          (B1),
      .Prog        (Prog),
      .Relock      (Relock),
      .correct     (correct),
      .incorrect   (incorrect),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .prog_done   (prog_done),
      .fail_cnt    (fail_cnt),
      .dbg_state_o (dbg_state)
   );

   initial mClk = 1'b0;
   always #5 mClk = ~mClk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge mClk);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic b);
      if (b) B1 = 1'b1;
      else   B0 = 1'b1;
      tick();
      B0 = 1'b0;
      B1 = 1'b0;
   endtask

   // Leaves the bench on the falling edge right after the completing press is sampled.
   task automatic enter_code(input logic [3:0] code);
      for (int i = 3; i >= 0; i--) begin
         press(code[i]);
         if (i != 0) tick();
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      Reset_n = 1'b0;
      B0      = 1'b0;
      B1      = 1'b0;
      Prog    = 1'b0;
      Relock  = 1'b0;
      ticks(2);

      chk("rst_correct",    32'(correct),    32'd0);
      chk("rst_incorrect",  32'(incorrect),  32'd0);
      chk("rst_unlocked",   32'(unlocked),   32'd0);
      chk("rst_locked_out", 32'(locked_out), 32'd0);
      chk("rst_prog_done",  32'(prog_done),  32'd0);
      chk("rst_fail_cnt",   32'(fail_cnt),   32'd0);
      chk("rst_state",      32'(dbg_state),  32'(ST_LOCKED));

      B1 = 1'b1;
      Reset_n = 1'b1;
      ticks(2);
      chk("held_at_release_state", 32'(dbg_state), 32'(ST_LOCKED));
      B1 = 1'b0;
      tick();

      enter_code(4'b1001);
      chk("open_correct",   32'(correct),   32'd1);
      chk("open_incorrect", 32'(incorrect), 32'd0);
      chk("open_unlocked",  32'(unlocked),  32'd1);
      chk("open_fail_cnt",  32'(fail_cnt),  32'd0);
      chk("open_state",     32'(dbg_state), 32'(ST_OPEN));
      tick();
      chk("open_correct_drop", 32'(correct), 32'd0);

      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      chk("relock_unlocked", 32'(unlocked),  32'd0);
      chk("relock_state",    32'(dbg_state), 32'(ST_LOCKED));

      enter_code(4'b0000);
      chk("bad1_incorrect", 32'(incorrect), 32'd1);
      chk("bad1_fail_cnt",  32'(fail_cnt),  32'd1);
      chk("bad1_state",     32'(dbg_state), 32'(ST_LOCKED));
      tick();
      chk("bad1_incorrect_drop", 32'(incorrect), 32'd0);
      enter_code(4'b0000);
      chk("bad2_incorrect", 32'(incorrect), 32'd1);
      chk("bad2_fail_cnt",  32'(fail_cnt),  32'd2);
      chk("bad2_state",     32'(dbg_state), 32'(ST_LOCKED));
      tick();
      enter_code(4'b0000);
      chk("bad3_incorrect",  32'(incorrect),  32'd1);
      chk("bad3_fail_cnt",   32'(fail_cnt),   32'd3);
      chk("bad3_locked_out", 32'(locked_out), 32'd1);
      chk("bad3_state",      32'(dbg_state),  32'(ST_LOCKOUT));

      ticks(5);
      press(1'b1);
      chk("lockout_press_state",     32'(dbg_state), 32'(ST_LOCKOUT));
      chk("lockout_press_fail_cnt",  32'(fail_cnt),  32'd3);
      chk("lockout_press_correct",   32'(correct),   32'd0);
      chk("lockout_press_incorrect", 32'(incorrect), 32'd0);
      ticks(25);
      chk("lockout_last_cycle", 32'(locked_out), 32'd1);
      tick();
      chk("lockout_end_locked_out", 32'(locked_out), 32'd0);
      chk("lockout_end_state",      32'(dbg_state),  32'(ST_LOCKED));
      chk("lockout_end_fail_cnt",   32'(fail_cnt),   32'd0);

      tick();
      press(1'b1);
      tick();
      press(1'b0);
      chk("partial_state", 32'(dbg_state), 32'(ST_ENTRY));
      ticks(15);
      chk("idle15_state", 32'(dbg_state), 32'(ST_ENTRY));
      tick();
      chk("idle16_state",     32'(dbg_state), 32'(ST_LOCKED));
      chk("idle16_correct",   32'(correct),   32'd0);
      chk("idle16_incorrect", 32'(incorrect), 32'd0);
      chk("idle16_fail_cnt",  32'(fail_cnt),  32'd0);
      enter_code(4'b1001);
      chk("after_timeout_correct", 32'(correct),   32'd1);
      chk("after_timeout_state",   32'(dbg_state), 32'(ST_OPEN));

      tick();
      Prog = 1'b1;
      tick();
      Prog = 1'b0;
      chk("prog_state",    32'(dbg_state), 32'(ST_PROG));
      chk("prog_unlocked", 32'(unlocked),  32'd1);
      tick();
      enter_code(4'b0110);
      chk("prog_done_pulse", 32'(prog_done), 32'd1);
      chk("prog_done_state", 32'(dbg_state), 32'(ST_OPEN));
      tick();
      chk("prog_done_drop", 32'(prog_done), 32'd0);
      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      chk("relock2_state", 32'(dbg_state), 32'(ST_LOCKED));
      enter_code(4'b1001);
      chk("old_code_incorrect", 32'(incorrect), 32'd1);
      chk("old_code_fail_cnt",  32'(fail_cnt),  32'd1);
      tick();
      enter_code(4'b0110);
      chk("new_code_correct",  32'(correct),  32'd1);
      chk("new_code_fail_cnt", 32'(fail_cnt), 32'd0);
      chk("new_code_unlocked", 32'(unlocked), 32'd1);

      tick();
      Prog   = 1'b1;
      Relock = 1'b1;
      tick();
      Prog   = 1'b0;
      Relock = 1'b0;
      chk("both_req_state",    32'(dbg_state), 32'(ST_LOCKED));
      chk("both_req_unlocked", 32'(unlocked),  32'd0);

      tick();
      press(1'b0);
      tick();
      B0 = 1'b1;
      B1 = 1'b1;
      tick();
      B0 = 1'b0;
      B1 = 1'b0;
      tick();
      press(1'b1);
      tick();
      press(1'b1);
      chk("simul_mid_state",     32'(dbg_state), 32'(ST_ENTRY));
      chk("simul_mid_incorrect", 32'(incorrect), 32'd0);
      tick();
      press(1'b0);
      chk("simul_correct", 32'(correct),   32'd1);
      chk("simul_state",   32'(dbg_state), 32'(ST_OPEN));

      tick();
      Prog = 1'b1;
      tick();
      Prog = 1'b0;
      tick();
      press(1'b0);
      tick();
      press(1'b1);
      tick();
      Reset_n = 1'b0;
      #1;
      chk("async_rst_state",    32'(dbg_state), 32'(ST_LOCKED));
      chk("async_rst_unlocked", 32'(unlocked),  32'd0);
      chk("async_rst_fail_cnt", 32'(fail_cnt),  32'd0);
      chk("async_rst_prog_done", 32'(prog_done), 32'd0);
      tick();
      Reset_n = 1'b1;
      tick();
      enter_code(4'b0110);
      chk("post_rst_0110_incorrect", 32'(incorrect), 32'd1);
      chk("post_rst_0110_fail_cnt",  32'(fail_cnt),  32'd1);
      tick();
      enter_code(4'b1001);
      chk("post_rst_1001_correct", 32'(correct),  32'd1);
      chk("post_rst_1001_fail",    32'(fail_cnt), 32'd0);

`ifdef LOCK_AUTO_RELOCK_EN
      ticks(15);
      chk("auto_relock_15", 32'(unlocked), 32'd1);
      tick();
      chk("auto_relock_16", 32'(unlocked),  32'd0);
      chk("auto_relock_st", 32'(dbg_state), 32'(ST_LOCKED));
`else
      ticks(40);
      chk("no_auto_relock_unlocked", 32'(unlocked),  32'd1);
      chk("no_auto_relock_state",    32'(dbg_state), 32'(ST_OPEN));
      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      chk("final_relock_state", 32'(dbg_state), 32'(ST_LOCKED));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
